// File: rtl/fft_pkg.sv
// Shared definitions for the FFT butterfly issue sequencer: state encoding,
// width derivations from the maximum transform size, and the outstanding-count update.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fft_state_t;

  function automatic int calc_log2_max(input int max_n);
    return $clog2(max_n);
  endfunction

  function automatic int calc_stage_w(input int max_n);
    return $clog2($clog2(max_n));
  endfunction

  function automatic int calc_pair_w(input int max_n);
    return $clog2(max_n / 2);
  endfunction

  function automatic int calc_cnt_w(input int max_n);
    return $clog2(max_n / 2 + 1);
  endfunction

  function automatic int calc_log2n_w(input int max_n);
    return $clog2($clog2(max_n) + 1);
  endfunction

  // Issue and write-back in the same cycle cancel; a clear with nothing in flight is dropped.
  function automatic logic [31:0] credit_next(input logic [31:0] cnt, input logic inc,
                                              input logic dec);
    logic [31:0] nxt;
    nxt = cnt;
    if (inc && !dec) begin
      nxt = cnt + 32'd1;
    end else if (dec && !inc && (cnt != 32'd0)) begin
      nxt = cnt - 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fft_credit_counter.sv
// Count of butterflies issued but not yet written back; cleared on abort.
module fft_credit_counter
  import fft_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= CNT_W'(credit_next(32'(count_q), inc, dec));
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fft_sequencer.sv
// Issues (stage, pair_id) butterfly addresses for an in-place radix-2 FFT and
// drains in-flight write-backs between stages to avoid read-after-write hazards.
module fft_sequencer
  import fft_pkg::*;
#(
  parameter int MAX_N = 1024
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               en,
  input  logic                               start,
  input  logic [calc_log2n_w(MAX_N)-1:0]     i_log2n,
  input  logic                               i_inverse,
  input  logic                               abort,
  input  logic                               io_busy,
  input  logic                               pipeline_clear,
  output logic [calc_stage_w(MAX_N)-1:0]     stage,
  output logic [calc_pair_w(MAX_N)-1:0]      pair_id,
  output logic                               valid,
  output logic                               bank_select,
  output logic                               o_inverse,
  output logic                               fft_busy,
  output logic                               fft_done,
  output logic                               o_err
);

  localparam int LOG2_MAX = calc_log2_max(MAX_N);
  localparam int STAGE_W  = calc_stage_w(MAX_N);
  localparam int PAIR_W   = calc_pair_w(MAX_N);
  localparam int CNT_W    = calc_cnt_w(MAX_N);
  localparam int LOG2N_W  = calc_log2n_w(MAX_N);

  fft_state_t         state_q, state_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [PAIR_W-1:0]  pair_q, pair_d;
  logic [LOG2N_W-1:0] log2n_q, log2n_d;
  logic               inv_q, inv_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   outstanding;
  logic [PAIR_W-1:0]  last_pair;
  logic [STAGE_W-1:0] last_stage;
  logic               size_ok;
  logic               abort_hit;

  assign size_ok    = (i_log2n >= LOG2N_W'(2)) && (i_log2n <= LOG2N_W'(LOG2_MAX));
  assign last_pair  = PAIR_W'((32'd1 << (32'(log2n_q) - 32'd1)) - 32'd1);
  assign last_stage = STAGE_W'(32'(log2n_q) - 32'd1);
  assign abort_hit  = abort && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      pair_q  <= '0;
      log2n_q <= '0;
      inv_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      pair_q  <= pair_d;
      log2n_q <= log2n_d;
      inv_q   <= inv_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    pair_d  = pair_q;
    log2n_d = log2n_q;
    inv_d   = inv_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && en && !io_busy) begin
          if (size_ok) begin
            log2n_d = i_log2n;
            inv_d   = i_inverse;
            stage_d = '0;
            pair_d  = '0;
            state_d = ST_ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (en) begin
          if (pair_q == last_pair) begin
            pair_d  = '0;
            state_d = ST_DRAIN;
          end else begin
            pair_d = pair_q + PAIR_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (en && (outstanding == '0)) begin
          if (stage_q == last_stage) begin
            state_d = ST_DONE;
          end else begin
            stage_d = stage_q + STAGE_W'(1);
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides whatever the state logic decided this cycle.
    if (abort_hit) begin
      state_d = ST_IDLE;
      stage_d = '0;
      pair_d  = '0;
    end
  end

  fft_credit_counter #(
    .CNT_W (CNT_W)
  ) u_credit (
    .clk   (clk),
    .reset (reset),
    .clr   (abort_hit),
    .inc   (valid),
    .dec   (pipeline_clear),
    .count (outstanding)
  );

  assign valid       = (state_q == ST_ISSUE) && en && !abort;
  assign stage       = stage_q;
  assign pair_id     = pair_q;
  assign bank_select = stage_q[0];
  assign o_inverse   = inv_q;
  assign fft_busy    = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign fft_done    = (state_q == ST_DONE);
  assign o_err       = err_q;

endmodule

// File: tb/tb_fft_sequencer.sv
// Directed scoreboard bench for fft_sequencer at MAX_N=32; butterfly write-backs
// are returned a few cycles after each issue by a small delay line.
module tb_fft_sequencer;

  localparam int MAX_N = 32;

  typedef struct {
    int stage;
    int pair;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       en;
  logic       start;
  logic [2:0] i_log2n;
  logic       i_inverse;
  logic       abort;
  logic       io_busy;
  logic       pipeline_clear;
  logic [2:0] stage;
  logic [3:0] pair_id;
  logic       valid;
  logic       bank_select;
  logic       o_inverse;
  logic       fft_busy;
  logic       fft_done;
  logic       o_err;

  logic       auto_clr;
  logic       manual_clr;
  logic [3:0] clr_pipe;
  int         tb_out;
  int         prev_stage;
  int         n_valid;
  int         n_checks;
  int         n_fail;
  exp_t       exp_q[$];

  assign pipeline_clear = auto_clr | manual_clr;

  fft_sequencer #(.MAX_N(MAX_N)) dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .start          (start),
    .i_log2n        (i_log2n),
    .i_inverse      (i_inverse),
    .abort          (abort),
    .io_busy        (io_busy),
    .pipeline_clear (pipeline_clear),
    .stage          (stage),
    .pair_id        (pair_id),
    .valid          (valid),
    .bank_select    (bank_select),
    .o_inverse      (o_inverse),
    .fft_busy       (fft_busy),
    .fft_done       (fft_done),
    .o_err          (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer and write-back model, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    logic new_clr;
    if (!reset || (abort && fft_busy)) begin
      tb_out   = 0;
      clr_pipe = '0;
      auto_clr = 1'b0;
    end else begin
      if (valid) begin
        n_valid++;
        if ((32'(stage) != prev_stage) && (stage != 3'd0))
          check("boundary_outstanding", 32'(tb_out), 32'd0);
        prev_stage = 32'(stage);
        check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("stage", 32'(stage), e.stage);
          check("pair_id", 32'(pair_id), e.pair);
          check("bank_select", 32'(bank_select), e.stage & 1);
        end
      end
      clr_pipe = {clr_pipe[2:0], valid};
      auto_clr = clr_pipe[3];
      new_clr  = auto_clr | manual_clr;
      if (valid && !new_clr) tb_out++;
      else if (!valid && new_clr && (tb_out > 0)) tb_out--;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_upto(input int log2n, input int last_s, input int last_p);
    exp_t e;
    for (int s = 0; s < log2n; s++)
      for (int p = 0; p < (1 << (log2n - 1)); p++)
        if ((s < last_s) || ((s == last_s) && (p <= last_p))) begin
          e.stage = s;
          e.pair  = p;
          exp_q.push_back(e);
        end
  endtask

  task automatic push_full(input int log2n);
    push_upto(log2n, log2n - 1, (1 << (log2n - 1)) - 1);
  endtask

  task automatic start_xfer(input int log2n, input logic inv);
    i_log2n   = 3'(log2n);
    i_inverse = inv;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    i_inverse = ~inv;
    @(negedge clk);
    check("busy_after_start", 32'(fft_busy), 32'd1);
    check("first_valid", 32'(valid), 32'd1);
  endtask

  task automatic run_xfer(input int budget, input logic exp_inv);
    int dones;
    int k_seen;
    bit seen;
    dones  = 0;
    k_seen = 0;
    seen   = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (fft_done) begin
        dones++;
        seen   = 1'b1;
        k_seen = k;
        check("busy_at_done", 32'(fft_busy), 32'd0);
        check("inverse_at_done", 32'(o_inverse), 32'(exp_inv));
      end
      if (seen && (k >= k_seen + 4)) break;
    end
    check("done_pulses", 32'(dones), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  task automatic wait_for(input int s, input int p);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (valid && (32'(stage) == s) && (32'(pair_id) == p)) begin
        found = 1'b1;
        break;
      end
    end
    check("reached_target", 32'(found), 32'd1);
    tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_stage"}, 32'(stage), 32'd0);
    check({tag, "_pair_id"}, 32'(pair_id), 32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_bank"}, 32'(bank_select), 32'd0);
    check({tag, "_inverse"}, 32'(o_inverse), 32'd0);
    check({tag, "_busy"}, 32'(fft_busy), 32'd0);
    check({tag, "_done"}, 32'(fft_done), 32'd0);
    check({tag, "_err"}, 32'(o_err), 32'd0);
  endtask

  initial begin
    int v0;
    int dones;
    n_checks = 0; n_fail = 0; n_valid = 0; tb_out = 0; prev_stage = 0;
    clr_pipe = '0; auto_clr = 1'b0; manual_clr = 1'b0;
    reset = 1'b0; en = 1'b1; start = 1'b0; i_log2n = '0; i_inverse = 1'b0;
    abort = 1'b0; io_busy = 1'b0;
    tick();
    check_idle_outputs("reset");
    reset = 1'b1;
    tick();

    // Full 32-point transform, inverse.
    push_full(5);
    v0 = n_valid;
    start_xfer(5, 1'b1);
    check("inverse_latched", 32'(o_inverse), 32'd1);
    run_xfer(600, 1'b1);
    check("valid_count_n32", 32'(n_valid - v0), 32'd80);

    // 8-point transform, forward.
    push_full(3);
    v0 = n_valid;
    start_xfer(3, 1'b0);
    run_xfer(200, 1'b0);
    check("valid_count_n8", 32'(n_valid - v0), 32'd12);

    // Out-of-range sizes.
    i_log2n = 3'd6; start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("err_big", 32'(o_err), 32'd1);
    check("err_big_busy", 32'(fft_busy), 32'd0);
    tick();
    @(negedge clk);
    check("err_big_pulse_end", 32'(o_err), 32'd0);
    tick();
    i_log2n = 3'd1; start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("err_small", 32'(o_err), 32'd1);
    check("err_small_busy", 32'(fft_busy), 32'd0);
    tick();
    @(negedge clk);
    check("err_small_pulse_end", 32'(o_err), 32'd0);
    tick();

    // Start held while the IO side owns the RAM, then held into the transform.
    push_full(2);
    io_busy = 1'b1; i_log2n = 3'd2; i_inverse = 1'b0; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("iobusy_hold_busy", 32'(fft_busy), 32'd0);
      check("iobusy_hold_err", 32'(o_err), 32'd0);
      tick();
    end
    io_busy = 1'b0;
    tick();
    @(negedge clk);
    check("iobusy_release_busy", 32'(fft_busy), 32'd1);
    check("iobusy_release_valid", 32'(valid), 32'd1);
    i_log2n = 3'd5;
    tick();
    tick();
    start = 1'b0;
    run_xfer(100, 1'b0);

    // Abort at stage 2, pair 7.
    push_upto(5, 2, 6);
    start_xfer(5, 1'b0);
    wait_for(2, 6);
    abort = 1'b1;
    @(negedge clk);
    check("abort_stage", 32'(stage), 32'd2);
    check("abort_pair", 32'(pair_id), 32'd7);
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("post_abort_valid", 32'(valid), 32'd0);
    check("post_abort_busy", 32'(fft_busy), 32'd0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (fft_done) dones++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(dones), 32'd0);
    check("abort_queue", 32'(exp_q.size()), 32'd0);
    check("abort_outstanding", 32'(dut.outstanding), 32'd0);
    tick();
    push_full(3);
    start_xfer(3, 1'b1);
    run_xfer(200, 1'b1);

    // Enable gap at pair 9 with a write-back landing inside it.
    push_full(5);
    start_xfer(5, 1'b0);
    wait_for(0, 8);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) manual_clr = 1'b1;
      @(negedge clk);
      check("gap_pair", 32'(pair_id), 32'd9);
      check("gap_valid", 32'(valid), 32'd0);
      tick();
      manual_clr = 1'b0;
      check("gap_outstanding", 32'(dut.outstanding), 32'(tb_out));
    end
    en = 1'b1;
    run_xfer(600, 1'b0);

    // Spurious clear with nothing in flight saturates at zero.
    manual_clr = 1'b1;
    tick();
    manual_clr = 1'b0;
    check("spurious_clear", 32'(dut.outstanding), 32'd0);

    // Reset in the middle of a transform.
    push_full(5);
    start_xfer(5, 1'b1);
    for (int i = 0; i < 20; i++) tick();
    #2 reset = 1'b0;
    #1 check_idle_outputs("async_reset");
    check("reset_outstanding", 32'(dut.outstanding), 32'd0);
    exp_q.delete();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("after_reset_valid", 32'(valid), 32'd0);
      check("after_reset_busy", 32'(fft_busy), 32'd0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
